// File: rtl/ram_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_sched
// Purpose  : Clears a single-port RAM after reset or on command, then
//            round-robin schedules req/ack accesses from two requesters.
// Revision : 1.0
// ============================================================================
module ram_access_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WR0,
    input  logic          WR1,
    input  logic [AW-1:0] A0,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_CLEAR = 3'd1,
        S_IDLE  = 3'd2,
        S_SERVE = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          last_q, last_d;
    logic          id_q, id_d;
    logic          wr_q, wr_d;
    logic          grant_id;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_START;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            last_q  <= last_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
        end
    end

    // With both requesting, the one not served last wins; otherwise whoever asks.
    assign grant_id = (REQ0 && REQ1) ? ~last_q : REQ1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        last_d  = last_q;
        id_d    = id_q;
        wr_d    = wr_q;
        BUSY    = 1'b0;
        RAM_WE  = 1'b0;
        RAM_A   = '0;
        RAM_DI  = '0;
        ACK0    = 1'b0;
        ACK1    = 1'b0;

        case (state_q)
            S_START: begin
                // Gated so every output reads 0 while reset is held.
                BUSY    = ~RST;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                BUSY   = 1'b1;
                RAM_WE = 1'b1;
                RAM_A  = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (CLR) begin
                    state_d = S_CLEAR;
                end else if (REQ0 || REQ1) begin
                    id_d    = grant_id;
                    last_d  = grant_id;
                    wr_d    = grant_id ? WR1 : WR0;
                    addr_d  = grant_id ? A1  : A0;
                    data_d  = grant_id ? D1  : D0;
                    state_d = S_SERVE;
                end
            end
            S_SERVE: begin
                RAM_WE = wr_q;
                RAM_A  = addr_q;
                RAM_DI = data_q;
                if (!wr_q) begin
                    rdata_d = RAM_DO;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                ACK0    = ~id_q;
                ACK1    = id_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign RDATA = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_sched
// Purpose  : Scoreboard bench for ram_access_sched with a behavioural RAM.
// Revision : 1.0
// ============================================================================
module tb_ram_access_sched;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 4;

    logic          CLK  = 1'b0;
    logic          RST  = 1'b1;
    logic          CLR  = 1'b0;
    logic          REQ0 = 1'b0;
    logic          REQ1 = 1'b0;
    logic          WR0  = 1'b0;
    logic          WR1  = 1'b0;
    logic [AW-1:0] A0   = '0;
    logic [AW-1:0] A1   = '0;
    logic [DW-1:0] D0   = '0;
    logic [DW-1:0] D1   = '0;
    logic          ACK0, ACK1, BUSY, RAM_WE;
    logic [DW-1:0] RDATA, RAM_DI, RAM_DO;
    logic [AW-1:0] RAM_A;

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] model [DEPTH];

    typedef struct packed {
        logic          id;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   ack_cyc[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;

    ram_access_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .BUSY(BUSY),
        .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
    );

    always #5 CLK = ~CLK;

    // RAM powers up with a nonzero pattern so a missing clear is visible.
    assign RAM_DO = mem[RAM_A];
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h7;
        end else if (RAM_WE) begin
            mem[RAM_A] <= RAM_DI;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (ACK0 || ACK1) begin
            ack_cyc.push_back(cyc);
            vec_cnt++;
            if (sb.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_ack: ACK0=%0b ACK1=%0b, required no ack", ACK0, ACK1);
            end else begin
                e = sb.pop_front();
                if ({ACK1, ACK0} !== (e.id ? 2'b10 : 2'b01)) begin
                    err_cnt++;
                    $display("FAIL ack_id: ACK1,ACK0=%b, required requester %0d", {ACK1, ACK0}, e.id);
                end
                if (e.rd) begin
                    vec_cnt++;
                    if (RDATA !== e.data) begin
                        err_cnt++;
                        $display("FAIL rdata: got %h, required %h", RDATA, e.data);
                    end
                end
            end
        end
    end

    function automatic void expect_access(input logic id, input logic wr,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.rd   = ~wr;
        e.data = wr ? d : model[a];
        if (wr) model[a] = d;
        sb.push_back(e);
    endfunction

    task automatic wait_drain(output int n);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: %0d acks outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_access(input logic id, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int lat);
        int n;
        @(posedge CLK); #1;
        expect_access(id, wr, a, d);
        if (id) begin
            WR1 = wr; A1 = a; D1 = d; REQ1 = 1'b1;
        end else begin
            WR0 = wr; A0 = a; D0 = d; REQ0 = 1'b1;
        end
        wait_drain(n);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        lat  = n - 1;
    endtask

    // Call at the start of the START cycle (just after reset release).
    task automatic check_clear_seq();
        int busy_n = 0;
        int we_n   = 0;
        logic [AW+DW-1:0] exp_v;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (RAM_WE) begin
                exp_v = {we_n[AW-1:0], {DW{1'b0}}};
                vec_cnt++;
                if ({RAM_A, RAM_DI} !== exp_v) begin
                    err_cnt++;
                    $display("FAIL clear_addr: A,DI=%h, required %h", {RAM_A, RAM_DI}, exp_v);
                end
                we_n++;
            end
        end
        vec_cnt++;
        if (busy_n !== 17) begin
            err_cnt++;
            $display("FAIL clear_busy_cycles: got %0d, required 17", busy_n);
        end
        vec_cnt++;
        if (we_n !== 16) begin
            err_cnt++;
            $display("FAIL clear_we_cycles: got %0d, required 16", we_n);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vec_cnt++;
        if ({ACK0, ACK1, BUSY, RAM_WE, RAM_A, RAM_DI, RDATA} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {ACK0, ACK1, BUSY, RAM_WE, RAM_A, RAM_DI, RDATA});
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        check_clear_seq();
    endtask

    task automatic test_read_all();
        int lat;
        for (int a = 0; a < DEPTH; a++) do_access(1'b1, 1'b0, a[AW-1:0], '0, lat);
    endtask

    task automatic test_arbitration();
        int n;
        @(posedge CLK); #1;
        ack_cyc.delete();
        expect_access(1'b0, 1'b1, 4'd1, 4'h3);
        expect_access(1'b1, 1'b1, 4'd2, 4'hC);
        expect_access(1'b0, 1'b1, 4'd1, 4'h3);
        expect_access(1'b1, 1'b1, 4'd2, 4'hC);
        WR0 = 1'b1; A0 = 4'd1; D0 = 4'h3;
        WR1 = 1'b1; A1 = 4'd2; D1 = 4'hC;
        REQ0 = 1'b1; REQ1 = 1'b1;
        wait_drain(n);
        REQ0 = 1'b0; REQ1 = 1'b0;
        vec_cnt++;
        if (ack_cyc.size() !== 4) begin
            err_cnt++;
            $display("FAIL arb_ack_count: got %0d, required 4", ack_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vec_cnt++;
                if (ack_cyc[i] - ack_cyc[i-1] !== 3) begin
                    err_cnt++;
                    $display("FAIL arb_spacing: got %0d cycles, required 3", ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
        do_access(1'b0, 1'b0, 4'd1, '0, n);
        do_access(1'b1, 1'b0, 4'd2, '0, n);
    endtask

    task automatic test_basic();
        int lat;
        do_access(1'b0, 1'b1, 4'd5, 4'hA, lat);
        vec_cnt++;
        if (lat !== 2) begin
            err_cnt++;
            $display("FAIL write_latency: got %0d, required 2", lat);
        end
        do_access(1'b0, 1'b0, 4'd5, '0, lat);
        vec_cnt++;
        if (lat !== 2) begin
            err_cnt++;
            $display("FAIL read_latency: got %0d, required 2", lat);
        end
    endtask

    task automatic test_clear();
        int lat;
        int n      = 0;
        int we_n   = 0;
        int busy_n = 0;
        do_access(1'b0, 1'b1, 4'd3, 4'hF, lat);
        @(posedge CLK); #1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        expect_access(1'b1, 1'b0, 4'd3, '0);
        CLR = 1'b1; WR1 = 1'b0; A1 = 4'd3; REQ1 = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge CLK);
            if (RAM_WE) we_n++;
            if (BUSY) busy_n++;
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL clr_timeout: ack1 missing, required one ack");
            sb.delete();
        end
        REQ1 = 1'b0;
        vec_cnt++;
        if (we_n !== 16) begin
            err_cnt++;
            $display("FAIL clr_we_cycles: got %0d, required 16", we_n);
        end
        vec_cnt++;
        if (busy_n !== 16) begin
            err_cnt++;
            $display("FAIL clr_busy_cycles: got %0d, required 16", busy_n);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int lat;
        @(posedge CLK); #1;
        WR0 = 1'b1; A0 = 4'd6; D0 = 4'h5; REQ0 = 1'b1;
        while (!(RAM_WE === 1'b1 && RAM_A === 4'd6) && n < 10) begin
            @(negedge CLK);
            n++;
        end
        vec_cnt++;
        if (n >= 10) begin
            err_cnt++;
            $display("FAIL rst_mid_serve: SERVE not seen, required write to A=6");
        end
        RST = 1'b1;
        #1;
        vec_cnt++;
        if ({ACK0, ACK1, BUSY, RAM_WE} !== 4'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_outputs: got %b, required 0000", {ACK0, ACK1, BUSY, RAM_WE});
        end
        REQ0 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check_clear_seq();
        do_access(1'b0, 1'b0, 4'd6, '0, lat);
    endtask

    task automatic test_addr_change();
        int n;
        @(posedge CLK); #1;
        expect_access(1'b0, 1'b1, 4'd4, 4'h9);
        WR0 = 1'b1; A0 = 4'd4; D0 = 4'h9; REQ0 = 1'b1;
        @(posedge CLK); #1;
        A0 = 4'd9;
        @(negedge CLK);
        vec_cnt++;
        if ({RAM_WE, RAM_A} !== {1'b1, 4'd4}) begin
            err_cnt++;
            $display("FAIL addr_hold: WE,A=%b, required 1_0100", {RAM_WE, RAM_A});
        end
        wait_drain(n);
        REQ0 = 1'b0;
        do_access(1'b0, 1'b0, 4'd4, '0, n);
        do_access(1'b1, 1'b0, 4'd9, '0, n);
    endtask

    initial begin
        test_reset();
        test_read_all();
        test_arbitration();
        test_basic();
        test_clear();
        test_reset_mid();
        test_addr_change();
        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ram_access_sched.md
# ram_access_sched

Access scheduler for the 16×4 single-port RAM (`RAM`: combinational read, write on `CLK` rising edge). It clears the array after reset or on command, then arbitrates read and write requests from two requesters. Arbitration is round-robin, and each requester uses a req/ack handshake. It drives the RAM's `WE`, `A` and write-data lines and returns registered read data, so the arithmetic-function datapath and a second client can share one array.

## Interface
Parameters:
- `DEPTH`, 16: words in the array. Must equal 2^`AW`.
- `AW`, 4: address width.
- `DW`, 4: data width.

Ports:
- `CLK`  in  1: clock. All state changes on the rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `CLR`  in  1: single-cycle pulse. Requests a full-array clear. Sampled only in IDLE.
- `REQ0`, `REQ1`  in  1 each: access request from requester 0 / 1. Held until ack.
- `WR0`, `WR1`  in  1 each: 1 = write, 0 = read. Held stable with REQ.
- `A0`, `A1`  in  AW each: access address. Held stable with REQ.
- `D0`, `D1`  in  DW each: write data. Held stable with REQ.
- `ACK0`, `ACK1`  out  1 each: single-cycle completion pulse.
- `RDATA`  out  DW: read data. Valid in the ACK cycle, held until the next read completes.
- `BUSY`  out  1: high in START and CLEAR.
- `RAM_WE`  out  1: write enable to the RAM.
- `RAM_A`  out  AW: address to the RAM.
- `RAM_DI`  out  DW: write data to the RAM.
- `RAM_DO`  in  DW: combinational read data from the RAM.

## Operation
- FSM states: START, CLEAR, IDLE, SERVE, ACK.
- Reset value of every output: all 0. Reset state is START, with clear counter = 0 and last-served pointer = 1.
- START: one cycle, then CLEAR. `BUSY` = 1 and `RAM_WE` = 0.
- CLEAR:
  - Drives `RAM_WE` = 1, `RAM_A` = counter, `RAM_DI` = 0.
  - Counter increments every cycle.
  - After the cycle with counter = DEPTH−1, the counter wraps to 0 and the FSM goes to IDLE.
  - Exactly DEPTH cycles. `BUSY` = 1 throughout.
  - REQ and `CLR` are ignored; requests stay pending.
- IDLE, evaluated in this priority order:
  - `CLR` = 1 → CLEAR. Clear beats pending requests.
  - Else, if exactly one REQ is high → grant that requester.
  - Else, if both are high → grant the requester that is not the last-served one.
  - On grant: latch the winner's id, WR, A and D into internal registers, update last-served, go to SERVE.
  - `RAM_WE` = 0 in IDLE.
- SERVE (one cycle):
  - `RAM_A` = latched address.
  - `RAM_WE` = latched WR.
  - `RAM_DI` = latched data.
  - On a read, `RDATA` <= `RAM_DO` at the closing edge. On a write, `RDATA` is unchanged.
  - Then ACK.
- ACK (one cycle): `ACK` of the latched id = 1, `RAM_WE` = 0, then IDLE.
- Requester rule: deassert REQ (or present a new request) by the edge ending the ACK cycle. A REQ still high in IDLE is treated as a new request.
- Inputs sampled only at grant. Changes to WR/A/D after grant do not affect the access in flight.
- `RAM_A` and `RAM_DI` = 0 in START, IDLE and ACK.
- `RST` asserted mid-access or mid-clear: immediate return to START.
  - No `ACK` is issued for the aborted access.
  - The clear restarts from address 0.

## Timing
- Request-to-ack latency from an idle scheduler: REQ high at edge k (in IDLE) → SERVE in cycle k+1 → `ACK` high in cycle k+2.
- Throughput: one access per 3 cycles. Back-to-back alternating grants when both requesters keep requesting.
- Write visibility: the write commits at the edge ending SERVE. A read of the same address granted afterwards returns the new value.
- Reset to first grant: 1 (START) + DEPTH (CLEAR) cycles. The earliest grant is at the edge ending the first IDLE cycle.
- `CLR` and a REQ in the same IDLE cycle: CLEAR runs first (DEPTH cycles), then the request is granted.

## Test plan
- Reset release → `BUSY` = 1 for 17 cycles and `RAM_WE` high for 16 of them, with `RAM_A` 0..15 and `RAM_DI` = 0. Then a read of addresses 0..15 returns `RDATA` = 0.
- `REQ0` write A = 5, D = 0xA, then `REQ0` read A = 5 → `ACK0` at cycle k+2 each time. The read gives `RDATA` = 0xA. `ACK1` never asserts.
- Both REQ held continuously with writes to A = 1 / A = 2 → grants alternate 0,1,0,1. The first grant after reset goes to requester 0 (last-served = 1).
- Write 0xF to A = 3, then `CLR` together with `REQ1` read A = 3 → 16 clear cycles, then `ACK1` with `RDATA` = 0.
- `RST` pulsed during SERVE of a write → no `ACK`, FSM restarts at START, and the full clear is observed again.
- Requester changes `A0` from 4 to 9 during SERVE → `RAM_A` = 4 throughout SERVE and the write lands at address 4 only.
